ni_packetizer: RTL and testbench

NI_PACKETIZER -- requirements
Module: ni_packetizer

---
 rtl/vc_router_pkg.sv | 33 +++
 rtl/ni_credit_counter.sv | 44 ++++
 rtl/ni_packetizer.sv | 163 ++++++++++++++++
 tb/tb_ni_packetizer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_router_pkg.sv
// vc_router_pkg -- shared types for the mesh router and its network interfaces.
//   flit_type_e  : flit type encoding (HEAD/BODY/TAIL/HEAD_TAIL)
//   flit_t       : packed flit {ftype, vc_id, src, dest, payload}
//   ni_state_e   : packetizer FSM state encoding
// Field widths are fixed here for the default mesh (16 routers, 4 VCs, 32-bit
// payload); modules that take matching parameters check them at elaboration.
package vc_router_pkg;

  localparam int ROUTER_ID_BITS = 4;
  localparam int VC_ID_BITS     = 2;
  localparam int PAYLOAD_BITS   = 32;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e                ftype;
    logic [VC_ID_BITS-1:0]     vc_id;
    logic [ROUTER_ID_BITS-1:0] src;
    logic [ROUTER_ID_BITS-1:0] dest;
    logic [PAYLOAD_BITS-1:0]   payload;
  } flit_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ni_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// ni_credit_counter -- per-VC credit counter, resets full (DEPTH credits).
//   clk, rst_n : clock, async active-low reset
//   inc        : credit returned by the router
//   dec        : flit sent (only asserted while count > 0)
//   count      : current credits
//   full       : count == DEPTH
//   ovf        : sticky, set by a return while already full; cleared only by reset
module ni_credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  assign full = (count == DEPTH_C);

  // Simultaneous inc and dec cancel: count is left as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= DEPTH_C;
      ovf   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (full) ovf <= 1'b1;
          else      count <= count + 1'b1;
        end
        2'b01: begin
          if (count != '0) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// ni_packetizer -- network-interface packetizer: splits an offered packet into
// FLITS_PER_PACKET flits on a freshly allocated VC of the router local port,
// under credit-based flow control.
//   clk, rst_n                 : clock, async active-low reset
//   pkt_valid/pkt_ready        : packet handshake (accepted on edge when both high)
//   pkt_dest, pkt_payload      : destination id, flit payloads (flit 0 in LSBs)
//   flit_valid, flit_out       : flit to router, consumed on every edge it is valid
//   credit_valid, credit_vc    : credit return from router
//   credit_err                 : sticky credit overflow
//   pkt_sent_count             : completed packets (only with NI_STATS_EN defined)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a packet; ready when a VC is idle with full credits
// ST_SEND | emitting flits of the latched packet on alloc_vc_q
module ni_packetizer
  import vc_router_pkg::*;
#(
  parameter int NUM_ROUTERS      = 16,
  parameter int ROUTER_PER_ROW   = 4,
  parameter int ROUTER_ID        = 0,
  parameter int NUM_VC           = 4,
  parameter int BUFFER_DEPTH     = 4,
  parameter int FLITS_PER_PACKET = 4,
  parameter int PAYLOAD_W        = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  pkt_valid,
  output logic                                  pkt_ready,
  input  logic [$clog2(NUM_ROUTERS)-1:0]        pkt_dest,
  input  logic [FLITS_PER_PACKET*PAYLOAD_W-1:0] pkt_payload,
  output logic                                  flit_valid,
  output flit_t                                 flit_out,
  input  logic                                  credit_valid,
  input  logic [$clog2(NUM_VC)-1:0]             credit_vc,
  output logic                                  credit_err
`ifdef NI_STATS_EN
  ,
  output logic [15:0]                           pkt_sent_count
`endif
);

  localparam int DW = $clog2(NUM_ROUTERS);
  localparam int VW = $clog2(NUM_VC);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int IW = (FLITS_PER_PACKET > 1) ? $clog2(FLITS_PER_PACKET) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FLITS_PER_PACKET - 1);

  // flit_t field widths come from the package, so the parameters must fit them.
  if (PAYLOAD_W != PAYLOAD_BITS || DW > ROUTER_ID_BITS || VW > VC_ID_BITS ||
      (NUM_ROUTERS % ROUTER_PER_ROW) != 0) begin : g_cfg_check
    $error("ni_packetizer: parameters do not match vc_router_pkg flit_t");
  end

  ni_state_e                         state_q, state_d;
  logic [DW-1:0]                     dest_q;
  logic [FLITS_PER_PACKET*PAYLOAD_W-1:0] payload_q;
  logic [VW-1:0]                     alloc_vc_q;
  logic [IW-1:0]                     idx_q;
  logic [NUM_VC-1:0]                 vc_busy_q;
  logic [NUM_VC-1:0]                 vc_full, vc_ovf, vc_inc, vc_dec, avail;
  logic [CW-1:0]                     vc_count [NUM_VC];
  logic [VW-1:0]                     free_vc;
  logic                              accept, send, is_tail;

  assign accept  = pkt_valid && pkt_ready;
  assign send    = flit_valid;
  assign is_tail = (idx_q == LAST_IDX);

  // Lowest-index allocatable VC wins.
  always_comb begin
    free_vc = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (avail[v]) free_vc = VW'(v);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (send && is_tail) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_ready  = 1'b0;
    flit_valid = 1'b0;
    flit_out   = '0;
    case (state_q)
      // rst_n gate keeps ready low while reset is held (counters read full then).
      ST_IDLE: pkt_ready = rst_n && (|avail);
      ST_SEND: begin
        flit_valid = (vc_count[alloc_vc_q] != '0);
        if (FLITS_PER_PACKET == 1) flit_out.ftype = FLIT_HEAD_TAIL;
        else if (idx_q == '0)      flit_out.ftype = FLIT_HEAD;
        else if (is_tail)          flit_out.ftype = FLIT_TAIL;
        else                       flit_out.ftype = FLIT_BODY;
        flit_out.vc_id   = VC_ID_BITS'(alloc_vc_q);
        flit_out.src     = ROUTER_ID_BITS'(ROUTER_ID);
        flit_out.dest    = ROUTER_ID_BITS'(dest_q);
        flit_out.payload = PAYLOAD_BITS'(payload_q[int'(idx_q)*PAYLOAD_W +: PAYLOAD_W]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q     <= '0;
      payload_q  <= '0;
      alloc_vc_q <= '0;
      idx_q      <= '0;
      vc_busy_q  <= '0;
    end else if (accept) begin
      dest_q              <= pkt_dest;
      payload_q           <= pkt_payload;
      alloc_vc_q          <= free_vc;
      idx_q               <= '0;
      vc_busy_q[free_vc]  <= 1'b1;
    end else if (send) begin
      if (is_tail) begin
        vc_busy_q[alloc_vc_q] <= 1'b0;
        idx_q                 <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign vc_inc[v] = credit_valid && (credit_vc == VW'(v));
    assign vc_dec[v] = send && (alloc_vc_q == VW'(v));
    assign avail[v]  = !vc_busy_q[v] && vc_full[v];

    ni_credit_counter #(.DEPTH(BUFFER_DEPTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (vc_inc[v]),
      .dec   (vc_dec[v]),
      .count (vc_count[v]),
      .full  (vc_full[v]),
      .ovf   (vc_ovf[v])
    );
  end

  assign credit_err = |vc_ovf;

`ifdef NI_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pkt_sent_count <= '0;
    else if (send && is_tail)  pkt_sent_count <= pkt_sent_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
module tb_ni_packetizer;
  import vc_router_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // u0: defaults, u1: BUFFER_DEPTH=2 / ROUTER_ID=5, u2: FLITS_PER_PACKET=1
  logic         pkt_valid0 = 0, pkt_ready0, flit_valid0, credit_valid0 = 0, credit_err0;
  logic [3:0]   pkt_dest0 = 0;
  logic [127:0] pkt_payload0 = 0;
  logic [1:0]   credit_vc0 = 0;
  flit_t        flit_out0;
  logic         pkt_valid1 = 0, pkt_ready1, flit_valid1, credit_valid1 = 0, credit_err1;
  logic [3:0]   pkt_dest1 = 0;
  logic [127:0] pkt_payload1 = 0;
  logic [1:0]   credit_vc1 = 0;
  flit_t        flit_out1;
  logic         pkt_valid2 = 0, pkt_ready2, flit_valid2, credit_valid2 = 0, credit_err2;
  logic [3:0]   pkt_dest2 = 0;
  logic [31:0]  pkt_payload2 = 0;
  logic [1:0]   credit_vc2 = 0;
  flit_t        flit_out2;
`ifdef NI_STATS_EN
  logic [15:0]  cnt0, cnt1, cnt2;
`endif

  ni_packetizer u0 (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid0), .pkt_ready(pkt_ready0),
    .pkt_dest(pkt_dest0), .pkt_payload(pkt_payload0), .flit_valid(flit_valid0),
    .flit_out(flit_out0), .credit_valid(credit_valid0), .credit_vc(credit_vc0),
    .credit_err(credit_err0)
`ifdef NI_STATS_EN
    , .pkt_sent_count(cnt0)
`endif
  );

  ni_packetizer #(.BUFFER_DEPTH(2), .ROUTER_ID(5)) u1 (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid1), .pkt_ready(pkt_ready1),
    .pkt_dest(pkt_dest1), .pkt_payload(pkt_payload1), .flit_valid(flit_valid1),
    .flit_out(flit_out1), .credit_valid(credit_valid1), .credit_vc(credit_vc1),
    .credit_err(credit_err1)
`ifdef NI_STATS_EN
    , .pkt_sent_count(cnt1)
`endif
  );

  ni_packetizer #(.FLITS_PER_PACKET(1)) u2 (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid2), .pkt_ready(pkt_ready2),
    .pkt_dest(pkt_dest2), .pkt_payload(pkt_payload2), .flit_valid(flit_valid2),
    .flit_out(flit_out2), .credit_valid(credit_valid2), .credit_vc(credit_vc2),
    .credit_err(credit_err2)
`ifdef NI_STATS_EN
    , .pkt_sent_count(cnt2)
`endif
  );

  flit_t q0[$], q1[$], q2[$];
  flit_t e0, e1, e2;

  typedef struct {
    logic [3:0]   dest;
    logic [127:0] payload;
    int           vc;
  } pkt_vec_t;
  pkt_vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic flit_t mk_flit(input int idx, input int n, input int vc,
                                    input int src, input int dest, input logic [31:0] pl);
    flit_t f;
    if (n == 1)            f.ftype = FLIT_HEAD_TAIL;
    else if (idx == 0)     f.ftype = FLIT_HEAD;
    else if (idx == n - 1) f.ftype = FLIT_TAIL;
    else                   f.ftype = FLIT_BODY;
    f.vc_id   = 2'(vc);
    f.src     = 4'(src);
    f.dest    = 4'(dest);
    f.payload = pl;
    return f;
  endfunction

  // Scoreboards: pop and compare each flit the DUT presents.
  always @(negedge clk) begin
    if (flit_valid0) begin
      total++;
      if (q0.size() == 0) begin
        bad++; $display("FAIL u0_unexpected_flit got=%h want=none", flit_out0);
      end else begin
        e0 = q0.pop_front();
        if (flit_out0 !== e0) begin
          bad++; $display("FAIL u0_flit got=%h want=%h", flit_out0, e0);
        end
      end
    end
    if (flit_valid1) begin
      total++;
      if (q1.size() == 0) begin
        bad++; $display("FAIL u1_unexpected_flit got=%h want=none", flit_out1);
      end else begin
        e1 = q1.pop_front();
        if (flit_out1 !== e1) begin
          bad++; $display("FAIL u1_flit got=%h want=%h", flit_out1, e1);
        end
      end
    end
    if (flit_valid2) begin
      total++;
      if (q2.size() == 0) begin
        bad++; $display("FAIL u2_unexpected_flit got=%h want=none", flit_out2);
      end else begin
        e2 = q2.pop_front();
        if (flit_out2 !== e2) begin
          bad++; $display("FAIL u2_flit got=%h want=%h", flit_out2, e2);
        end
      end
    end
  end

  // Offer a packet: wait (bounded) for ready at a negedge, then assert valid so
  // it is accepted on the following posedge. Returns just after that posedge.
  task automatic offer0(input logic [3:0] d, input logic [127:0] p, input int vc, output int waited);
    waited = 0;
    pkt_dest0 = d; pkt_payload0 = p;
    @(negedge clk);
    while (!pkt_ready0 && waited < 100) begin @(negedge clk); waited++; end
    chk("u0_offer_ready", pkt_ready0, 1);
    if (pkt_ready0) begin
      pkt_valid0 = 1;
      for (int i = 0; i < 4; i++) q0.push_back(mk_flit(i, 4, vc, 0, d, p[i*32 +: 32]));
    end
    @(posedge clk); #1 pkt_valid0 = 0;
  endtask

  task automatic offer1(input logic [3:0] d, input logic [127:0] p, input int vc);
    int waited;
    waited = 0;
    pkt_dest1 = d; pkt_payload1 = p;
    @(negedge clk);
    while (!pkt_ready1 && waited < 100) begin @(negedge clk); waited++; end
    chk("u1_offer_ready", pkt_ready1, 1);
    if (pkt_ready1) begin
      pkt_valid1 = 1;
      for (int i = 0; i < 4; i++) q1.push_back(mk_flit(i, 4, vc, 5, d, p[i*32 +: 32]));
    end
    @(posedge clk); #1 pkt_valid1 = 0;
  endtask

  task automatic offer2(input logic [3:0] d, input logic [31:0] p, input int vc);
    int waited;
    waited = 0;
    pkt_dest2 = d; pkt_payload2 = p;
    @(negedge clk);
    while (!pkt_ready2 && waited < 100) begin @(negedge clk); waited++; end
    chk("u2_offer_ready", pkt_ready2, 1);
    if (pkt_ready2) begin
      pkt_valid2 = 1;
      q2.push_back(mk_flit(0, 1, vc, 0, d, p));
    end
    @(posedge clk); #1 pkt_valid2 = 0;
  endtask

  task automatic ret0(input int vc, input int n);
    for (int i = 0; i < n; i++) begin
      credit_valid0 = 1; credit_vc0 = 2'(vc);
      @(posedge clk); #1 credit_valid0 = 0;
    end
  endtask

  task automatic wait_q0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("u0_drain", q0.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    tbl[0] = '{dest: 4'd8,  payload: 128'h44440004_33330003_22220002_11110001, vc: 0};
    tbl[1] = '{dest: 4'd3,  payload: 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0, vc: 0};
    tbl[2] = '{dest: 4'd15, payload: 128'hB0B0B0B3_B0B0B0B2_B0B0B0B1_B0B0B0B0, vc: 1};
    tbl[3] = '{dest: 4'd1,  payload: 128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_C0C0C0C0, vc: 2};
    tbl[4] = '{dest: 4'd12, payload: 128'hD0D0D0D3_D0D0D0D2_D0D0D0D1_D0D0D0D0, vc: 3};
    tbl[5] = '{dest: 4'd6,  payload: 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, vc: 0};

    // Reset state while rst_n held low.
    #2;
    chk("rst_pkt_ready", pkt_ready0, 0);
    chk("rst_flit_valid", flit_valid0, 0);
    chk("rst_flit_out", flit_out0, 0);
    chk("rst_credit_err", credit_err0, 0);
    chk("rst_pkt_ready_u1", pkt_ready1, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;

    // Basic packet, accepted on first edge after reset release.
    offer0(tbl[0].dest, tbl[0].payload, tbl[0].vc, w);
    chk("first_accept_wait", w, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("consecutive_flits", flit_valid0, 1);
    end
    @(negedge clk); chk("idle_after_tail", flit_valid0, 0);
    ret0(0, 4);

    // Four back-to-back packets with no credit return: VC0..VC3 in order.
    for (int i = 1; i <= 4; i++) offer0(tbl[i].dest, tbl[i].payload, tbl[i].vc, w);
    wait_q0();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("fifth_blocked", pkt_ready0, 0);
      ret0(0, 1);
    end
    offer0(tbl[5].dest, tbl[5].payload, tbl[5].vc, w);
    chk("fifth_ready_after_4_credits", w, 0);
    wait_q0();
    ret0(0, 4); ret0(1, 4); ret0(2, 4); ret0(3, 4);
    @(negedge clk); chk("no_err_after_restore", credit_err0, 0);

    // Same-edge send and credit return on the allocated VC.
    offer0(4'd9, 128'h0F0F0003_0F0F0002_0F0F0001_0F0F0000, 0, w);
    credit_valid0 = 1; credit_vc0 = 2'd0;
    @(posedge clk); #1 credit_valid0 = 0;
    wait_q0();
    ret0(0, 3);
    @(negedge clk); chk("same_edge_no_ovf", credit_err0, 0);
    offer0(4'd10, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, w);
    wait_q0();
    ret0(0, 4);
    @(negedge clk); chk("still_no_ovf", credit_err0, 0);
    ret0(2, 1);
    @(negedge clk); chk("excess_credit_err", credit_err0, 1);
    repeat (5) @(posedge clk);
    @(negedge clk); chk("credit_err_sticky", credit_err0, 1);

    // Reset mid-packet, after the second flit.
    offer0(4'd5, 128'h5555_0003_5555_0002_5555_0001_5555_0000, 0, w);
    @(posedge clk); @(posedge clk); #1 rst_n = 0;
    #1;
    chk("midrst_flit_valid", flit_valid0, 0);
    chk("midrst_pkt_ready", pkt_ready0, 0);
    chk("midrst_flit_out", flit_out0, 0);
    chk("midrst_credit_err", credit_err0, 0);
    q0.delete();
    @(posedge clk); #1 rst_n = 1;
    offer0(4'd7, 128'h7777_0003_7777_0002_7777_0001_7777_0000, 0, w);
    chk("post_rst_accept_wait", w, 0);
    wait_q0();

    // Credit starvation with BUFFER_DEPTH=2.
    offer1(4'd2, 128'h2B2B0003_2B2B0002_2B2B0001_2B2B0000, 0);
    @(negedge clk); chk("bd2_flit0", flit_valid1, 1);
    @(negedge clk); chk("bd2_flit1", flit_valid1, 1);
    @(negedge clk); chk("bd2_stall", flit_valid1, 0);
    credit_valid1 = 1; credit_vc1 = 2'd0;
    @(posedge clk); #1 credit_valid1 = 0;
    @(negedge clk); chk("bd2_flit2_after_credit", flit_valid1, 1);
    @(negedge clk); chk("bd2_stall2", flit_valid1, 0);
    credit_valid1 = 1; credit_vc1 = 2'd0;
    @(posedge clk); #1 credit_valid1 = 0;
    @(negedge clk); chk("bd2_tail_after_credit", flit_valid1, 1);
    @(negedge clk); chk("bd2_done", flit_valid1, 0);
    chk("bd2_ready_vc1", pkt_ready1, 1);
    chk("bd2_q_empty", q1.size(), 0);
    chk("bd2_no_err", credit_err1, 0);

    // Single-flit packets.
    for (int i = 0; i < 3; i++) begin
      offer2(4'(i + 1), 32'hF1F10000 + 32'(i), i);
      @(negedge clk); chk("ht_valid", flit_valid2, 1);
      @(negedge clk); chk("ht_single_cycle", flit_valid2, 0);
    end
    chk("ht_q_empty", q2.size(), 0);
    chk("ht_no_err", credit_err2, 0);
`ifdef NI_STATS_EN
    chk("pkt_sent_count", cnt2, 3);
`endif

    chk("u0_q_empty_end", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
